fetch_unit: RTL and testbench

Instruction-fetch stage for the two-accumulator 8-bit core. It owns the 7-bit program counter and drives a synchronous-read 128x16 program ROM. It registers the fetched word into the instruction register that feeds the decoder. It also applies the decoder's branch redirect (branch taken, branch target) and flushes wrong-path words.

---
 rtl/fetch_unit.sv | 90 +++++++++
 tb/tb_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: PC + sync ROM address, instruction register, branch redirect with 2-bubble flush.
// Latency 2 edges ROM-issue to rInstruction; wStall freezes all state, and redirect overrides stall.
module fetch_unit #(
  parameter logic [6:0]  RESET_PC  = 7'd0,
  parameter logic [15:0] NOP_INSTR = 16'hFFFF
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        wStall,
  input  logic        wBranch_taken,
  input  logic [6:0]  wBranch_dir,
  input  logic [15:0] wRomData,
  output logic [6:0]  rRomAddr,
  output logic [15:0] rInstruction,
  output logic        rInstr_valid,
  output logic [6:0]  rInstr_pc,
  output logic [15:0] rFetch_count
);

  // Encoding is {flight_valid, instr_valid}; BUBBLE (2'b01) cannot be reached.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FILL  = 2'b10,
    RUN   = 2'b11
  } fetch_state_t;

  fetch_state_t state_q, state_d;
  logic [6:0]   pc_q, pc_d;
  logic [6:0]   flight_pc_q, flight_pc_d;
  logic [15:0]  instr_q, instr_d;
  logic [6:0]   instr_pc_q, instr_pc_d;
  logic [15:0]  count_q, count_d;

  logic flight_vld;
  logic instr_vld;
  logic redirect;

  assign flight_vld = state_q[1];
  assign instr_vld  = state_q[0];
  assign redirect   = wBranch_taken && instr_vld;

  // While stalled the ROM re-reads the in-flight word so wRomData stays valid.
  assign rRomAddr     = wStall ? flight_pc_q : pc_q;
  assign rInstruction = instr_q;
  assign rInstr_valid = instr_vld;
  assign rInstr_pc    = instr_pc_q;
  assign rFetch_count = count_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flight_pc_d = flight_pc_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    count_d     = count_q;
    if (redirect) begin
      state_d = EMPTY;
      pc_d    = wBranch_dir;
      instr_d = NOP_INSTR;
    end else if (!wStall) begin
      state_d     = flight_vld ? RUN : FILL;
      pc_d        = pc_q + 7'd1;
      flight_pc_d = pc_q;
      instr_d     = flight_vld ? wRomData : NOP_INSTR;
      instr_pc_d  = flight_pc_q;
      if (flight_vld && (count_q != 16'hFFFF)) begin
        count_d = count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= EMPTY;
      pc_q        <= RESET_PC;
      flight_pc_q <= RESET_PC;
      instr_q     <= NOP_INSTR;
      instr_pc_q  <= 7'd0;
      count_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      flight_pc_q <= flight_pc_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stall/branch/wrap/async-reset cases plus random stall/branch traffic,
// all checked against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'hFFFF;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        wStall = 1'b0;
  logic        wBranch_taken = 1'b0;
  logic [6:0]  wBranch_dir = 7'd0;
  logic [15:0] wRomData = 16'd0;
  logic [6:0]  rRomAddr;
  logic [15:0] rInstruction;
  logic        rInstr_valid;
  logic [6:0]  rInstr_pc;
  logic [15:0] rFetch_count;

  // Second instance checks the RESET_PC wrap case; it free-runs without stall or branch.
  logic [15:0] rom2_dat = 16'd0;
  logic [6:0]  addr2;
  logic [15:0] instr2;
  logic        vld2;
  logic [6:0]  ipc2;
  logic [15:0] cnt2;

  logic [15:0] rom [128];

  int n_vec = 0;
  int n_bad = 0;

  // Model: next address, whether a word is in flight and from where, plus the visible register.
  logic [6:0]  m_pc;
  logic        m_inf;
  logic [6:0]  m_last;
  logic [15:0] m_instr;
  logic        m_vld;
  logic [6:0]  m_ipc;
  logic [15:0] m_cnt;

  fetch_unit u_dut (
    .Clock(Clock), .Reset(Reset), .wStall(wStall), .wBranch_taken(wBranch_taken),
    .wBranch_dir(wBranch_dir), .wRomData(wRomData), .rRomAddr(rRomAddr),
    .rInstruction(rInstruction), .rInstr_valid(rInstr_valid), .rInstr_pc(rInstr_pc),
    .rFetch_count(rFetch_count)
  );

  fetch_unit #(.RESET_PC(7'd126)) u_dut2 (
    .Clock(Clock), .Reset(Reset), .wStall(1'b0), .wBranch_taken(1'b0),
    .wBranch_dir(7'd0), .wRomData(rom2_dat), .rRomAddr(addr2),
    .rInstruction(instr2), .rInstr_valid(vld2), .rInstr_pc(ipc2),
    .rFetch_count(cnt2)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    wRomData <= rom[rRomAddr];
    rom2_dat <= rom[addr2];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 7'd0; m_inf = 1'b0; m_last = 7'd0;
    m_instr = NOP; m_vld = 1'b0; m_ipc = 7'd0; m_cnt = 16'd0;
  endtask

  task automatic model_edge(input logic st, input logic br, input logic [6:0] dir);
    if (br && m_vld) begin
      m_pc = dir; m_inf = 1'b0; m_instr = NOP; m_vld = 1'b0;
    end else if (!st) begin
      m_instr = m_inf ? rom[m_last] : NOP;
      m_vld   = m_inf;
      m_ipc   = m_last;
      if (m_inf && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_last = m_pc;
      m_inf  = 1'b1;
      m_pc   = m_pc + 7'd1;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".instr"}, {16'd0, rInstruction}, {16'd0, m_instr});
    chk({tag, ".vld"},   {31'd0, rInstr_valid}, {31'd0, m_vld});
    chk({tag, ".ipc"},   {25'd0, rInstr_pc},    {25'd0, m_ipc});
    chk({tag, ".cnt"},   {16'd0, rFetch_count}, {16'd0, m_cnt});
  endtask

  // Called one time unit after a rising edge; drives inputs, checks the ROM address, clocks, checks.
  task automatic cyc(input string tag, input logic st, input logic br, input logic [6:0] dir);
    wStall = st; wBranch_taken = br; wBranch_dir = dir;
    #1;
    chk({tag, ".romaddr"}, {25'd0, rRomAddr}, {25'd0, (st ? m_last : m_pc)});
    @(posedge Clock);
    model_edge(st, br, dir);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [6:0] exp2 [4];
    logic       seen_100b;
    int         guard;
    exp2[0] = 7'd126; exp2[1] = 7'd127; exp2[2] = 7'd0; exp2[3] = 7'd1;
    for (int i = 0; i < 128; i++) rom[i] = 16'h1000 + 16'(i);
    model_reset();

    // Reset state, then release between edges.
    #12;
    check_outputs("reset");
    chk("reset.romaddr", {25'd0, rRomAddr}, 32'd0);
    Reset = 1'b1;
    @(posedge Clock); #1;
    model_edge(1'b0, 1'b0, 7'd0);
    check_outputs("edge1");
    chk("edge1.nop", {16'd0, rInstruction}, {16'd0, NOP});
    for (int k = 2; k <= 6; k++) begin
      cyc("fill", 1'b0, 1'b0, 7'd0);
      if (k <= 5) chk("wrap126.ipc", {25'd0, ipc2}, {25'd0, exp2[k-2]});
      if (k == 2) chk("first_word", {16'd0, rInstruction}, 32'h1000);
    end

    // Advance to the word at address 5, then stall for three cycles.
    guard = 0;
    while (m_ipc != 7'd5 && guard < 200) begin cyc("seek5", 1'b0, 1'b0, 7'd0); guard++; end
    chk("seek5.reached", {25'd0, rInstr_pc}, 32'd5);
    for (int k = 0; k < 3; k++) begin
      cyc("stall", 1'b1, 1'b0, 7'd0);
      chk("stall.instr", {16'd0, rInstruction}, 32'h1005);
      chk("stall.romaddr", {25'd0, rRomAddr}, 32'd6);
    end
    cyc("unstall", 1'b0, 1'b0, 7'd0);
    chk("unstall.next", {16'd0, rInstruction}, 32'h1006);

    // Branch to 40 while the word at 10 is in the instruction register.
    guard = 0;
    while (m_ipc != 7'd10 && guard < 200) begin cyc("seek10", 1'b0, 1'b0, 7'd0); guard++; end
    seen_100b = 1'b0;
    cyc("br", 1'b0, 1'b1, 7'd40);
    for (int k = 0; k < 2; k++) begin
      cyc("br.bubble", 1'b0, 1'b0, 7'd0);
      if (rInstruction == 16'h100B) seen_100b = 1'b1;
    end
    chk("br.target", {16'd0, rInstruction}, 32'h1028);
    chk("br.target_pc", {25'd0, rInstr_pc}, 32'd40);
    chk("br.no_100b", {31'd0, seen_100b}, 32'd0);

    // Branch together with stall: redirect wins.
    cyc("brst.pre", 1'b0, 1'b0, 7'd0);
    cyc("brst", 1'b1, 1'b1, 7'd40);
    chk("brst.flush", {31'd0, rInstr_valid}, 32'd0);
    cyc("brst.b1", 1'b0, 1'b0, 7'd0);
    cyc("brst.b2", 1'b0, 1'b0, 7'd0);
    chk("brst.target", {16'd0, rInstruction}, 32'h1028);

    // Random traffic, including branches that target the current word.
    for (int i = 0; i < 600; i++) begin
      logic st, br;
      logic [6:0] dir;
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 6) == 0);
      dir = ($urandom_range(0, 3) == 0) ? m_ipc : 7'($urandom_range(0, 127));
      cyc("rand", st, br, dir);
    end

    // Async reset mid-stall during FILL.
    guard = 0;
    while (!m_vld && guard < 10) begin cyc("seekv", 1'b0, 1'b0, 7'd0); guard++; end
    cyc("ar.redir", 1'b0, 1'b1, 7'd126);
    cyc("ar.fill", 1'b0, 1'b0, 7'd0);
    wStall = 1'b1;
    #2;
    Reset = 1'b0;
    #1;
    model_reset();
    check_outputs("areset");
    chk("areset.romaddr", {25'd0, rRomAddr}, 32'd0);
    #3;
    Reset = 1'b1;
    wStall = 1'b0;
    @(posedge Clock); #1;
    model_edge(1'b0, 1'b0, 7'd0);
    check_outputs("post_ar");
    for (int k = 0; k < 4; k++) cyc("post_ar", 1'b0, 1'b0, 7'd0);
    chk("post_ar.ipc", {25'd0, rInstr_pc}, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
